// File: rtl/mdu_seq_pkg.sv
// mdu_seq_pkg: shared definitions for the multiply/divide sequencer.
//   - MDUop_* operation codes as issued from the E stage
//   - 2-bit FSM state encoding
//   - small op-class helpers used by the sequencer and the arithmetic block
package mdu_seq_pkg;

    localparam logic [3:0] MDUOP_MULT  = 4'd0;
    localparam logic [3:0] MDUOP_MULTU = 4'd1;
    localparam logic [3:0] MDUOP_DIV   = 4'd2;
    localparam logic [3:0] MDUOP_DIVU  = 4'd3;
    localparam logic [3:0] MDUOP_MFHI  = 4'd4;
    localparam logic [3:0] MDUOP_MFLO  = 4'd5;
    localparam logic [3:0] MDUOP_MTHI  = 4'd6;
    localparam logic [3:0] MDUOP_MTLO  = 4'd7;
    localparam logic [3:0] MDUOP_NONE  = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10
    } mdu_state_e;

    // Codes 8..14 are undefined and behave like "none".
    function automatic logic [3:0] sanitize_op(input logic [3:0] op);
        return op[3] ? MDUOP_NONE : op;
    endfunction

    // Multi-cycle ops: mult, multu, div, divu.
    function automatic logic is_md_op(input logic [3:0] op);
        return (op[3:2] == 2'b00);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MDUOP_DIV) || (op == MDUOP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_seq_if.sv
// mdu_seq_if: E-stage <-> MDU connection.
//   master (pipeline side): drives issue, mdu_op, a, b, d_md_use
//   slave  (MDU side)     : drives busy, stall_md, hi, lo, mdu_out
interface mdu_seq_if;
    logic        issue;
    logic [3:0]  mdu_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        d_md_use;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mdu_out;

    modport master (
        output issue, mdu_op, a, b, d_md_use,
        input  busy, stall_md, hi, lo, mdu_out
    );

    modport slave (
        input  issue, mdu_op, a, b, d_md_use,
        output busy, stall_md, hi, lo, mdu_out
    );
endinterface

// File: rtl/mdu_seq_arith.sv
// mdu_arith: purely combinational multiply/divide datapath.
//   a, b     : operands (rs, rt)
//   op       : sanitized MDUop code
//   res_hi   : product[63:32] or remainder
//   res_lo   : product[31:0]  or quotient
//   div_zero : div/divu with a zero divisor (result must not be committed)
module mdu_arith
    import mdu_seq_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  op,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_zero
);

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic               sgn;
    logic [31:0]        mag_a;
    logic [31:0]        mag_b;
    logic [31:0]        dvsr;
    logic [31:0]        q_mag;
    logic [31:0]        r_mag;

    always_comb begin
        prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        prod_u = {32'd0, a} * {32'd0, b};

        // Signed divide is done on magnitudes and the signs reapplied:
        // quotient truncates toward zero, remainder follows the dividend.
        // 0x80000000 / -1 falls out as quotient 0x80000000, remainder 0.
        sgn   = (op == MDUOP_DIV);
        mag_a = (sgn && a[31]) ? (~a + 32'd1) : a;
        mag_b = (sgn && b[31]) ? (~b + 32'd1) : b;
        // Keep the divider defined for b == 0; the result is discarded anyway.
        dvsr  = (b == 32'd0) ? 32'd1 : mag_b;
        q_mag = mag_a / dvsr;
        r_mag = mag_a % dvsr;

        res_hi   = 32'd0;
        res_lo   = 32'd0;
        div_zero = is_div_op(op) && (b == 32'd0);

        case (op)
            MDUOP_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            MDUOP_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            MDUOP_DIV: begin
                res_lo = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
                res_hi = a[31] ? (~r_mag + 32'd1) : r_mag;
            end
            MDUOP_DIVU: begin
                res_lo = q_mag;
                res_hi = r_mag;
            end
            default: begin
                res_hi = 32'd0;
                res_lo = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle multiply/divide sequencer beside the E-stage ALU.
//   clk   : clock, rising edge
//   reset : asynchronous, active-low
//   bus   : mdu_seq_if.slave (issue/op/operands in; busy, stall, HI/LO, read data out)
// The full result is computed at issue and held in res_hi/res_lo; it is
// committed to HI/LO on the edge where the latency counter expires.
//
// state   | meaning
// --------+---------------------------------------------
// ST_IDLE | no op in flight; accepts Md, mthi/mtlo
// ST_MUL  | mult/multu in flight, cnt counts down to 0
// ST_DIV  | div/divu in flight, cnt counts down to 0
module mdu_seq
    import mdu_seq_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
)(
    input  logic       clk,
    input  logic       reset,
    mdu_seq_if.slave   bus
);

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    mdu_state_e  state, state_nx;
    logic [3:0]  cnt;
    logic [31:0] hi_q, lo_q;
    logic [31:0] res_hi, res_lo;
    logic        res_dz;

    logic [3:0]  op_eff;
    logic        md_req;
    logic        md_start;
    logic [31:0] ar_hi, ar_lo;
    logic        ar_dz;

    assign op_eff   = sanitize_op(bus.mdu_op);
    assign md_req   = bus.issue && is_md_op(op_eff);
    assign md_start = md_req && (state == ST_IDLE);

    mdu_arith u_arith (
        .a        (bus.a),
        .b        (bus.b),
        .op       (op_eff),
        .res_hi   (ar_hi),
        .res_lo   (ar_lo),
        .div_zero (ar_dz)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (md_start) state_nx = is_div_op(op_eff) ? ST_DIV : ST_MUL;
            end
            ST_MUL, ST_DIV: begin
                if (cnt == 4'd0) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.busy     = (state != ST_IDLE);
        bus.stall_md = bus.d_md_use && (bus.busy || md_req);
        bus.mdu_out  = (op_eff == MDUOP_MFHI) ? hi_q : lo_q;
    end

    assign bus.hi = hi_q;
    assign bus.lo = lo_q;

    // Counter, pending result and architectural HI/LO. Issues arriving
    // while an op is in flight are ignored here on purpose.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= 4'd0;
            res_hi <= 32'd0;
            res_lo <= 32'd0;
            res_dz <= 1'b0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
        end else if (state == ST_IDLE) begin
            if (md_start) begin
                res_hi <= ar_hi;
                res_lo <= ar_lo;
                res_dz <= ar_dz;
                cnt    <= is_div_op(op_eff) ? DIV_LOAD : MULT_LOAD;
            end else if (bus.issue && op_eff == MDUOP_MTHI) begin
                hi_q <= bus.a;
            end else if (bus.issue && op_eff == MDUOP_MTLO) begin
                lo_q <= bus.a;
            end
        end else begin
            if (cnt == 4'd0) begin
                if (!res_dz) begin
                    hi_q <= res_hi;
                    lo_q <= res_lo;
                end
            end else begin
                cnt <= cnt - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
module tb_mdu_seq;

    logic clk;
    logic reset;

    mdu_seq_if bus ();

    mdu_seq #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] mdl_hi = 32'd0;
    logic [31:0] mdl_lo = 32'd0;
    bit          abort  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: architectural result of an Md op given current HI/LO.
    function automatic void ref_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   inout logic [31:0] h, inout logic [31:0] l);
        longint          sa, sb_, p, q, r;
        longint unsigned pu;
        sa = longint'($signed(a));
        sb_ = longint'($signed(b));
        pu = 64'(a) * 64'(b);
        case (op)
            4'd0: begin p = sa * sb_; h = p[63:32]; l = p[31:0]; end
            4'd1: begin h = pu[63:32]; l = pu[31:0]; end
            4'd2: if (b != 0) begin q = sa / sb_; r = sa % sb_; l = q[31:0]; h = r[31:0]; end
            4'd3: if (b != 0) begin l = a / b; h = a % b; end
            default: ;
        endcase
    endfunction

    // Issue one op in the first idle cycle; returns one step after the issue edge.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic dmd);
        int          guard;
        logic        md;
        logic [31:0] eh, el;
        guard = 0;
        @(negedge clk);
        while (bus.busy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            total++; bad++;
            $display("FAIL busy_timeout actual=busy required=idle t=%0t", $time);
        end
        bus.issue    = 1'b1;
        bus.mdu_op   = op;
        bus.a        = a;
        bus.b        = b;
        bus.d_md_use = dmd;
        #1;
        md = (op <= 4'd3);
        chk("stall_issue", 32'(bus.stall_md), 32'(dmd & md));
        if (op == 4'd4) chk("mfhi_read", bus.mdu_out, mdl_hi);
        if (op == 4'd5) chk("mflo_read", bus.mdu_out, mdl_lo);
        if (md) begin
            eh = mdl_hi;
            el = mdl_lo;
            ref_md(op, a, b, eh, el);
            sb.push_back('{hi: eh, lo: el, n: (op >= 4'd2) ? 10 : 5});
            mdl_hi = eh;
            mdl_lo = el;
        end
        @(posedge clk);
        #1;
        bus.issue  = 1'b0;
        bus.mdu_op = 4'd15;
        if (op == 4'd6) mdl_hi = a;
        if (op == 4'd7) mdl_lo = a;
        if (op == 4'd6 || op == 4'd7) begin
            chk("mt_hi", bus.hi, mdl_hi);
            chk("mt_lo", bus.lo, mdl_lo);
        end
    endtask

    // Monitor: on each busy fall, compare committed HI/LO and busy length.
    initial begin : monitor
        bit   busy_prev;
        int   run;
        exp_t e;
        busy_prev = 1'b0;
        run = 0;
        forever begin
            @(negedge clk);
            if (bus.issue && bus.busy && !bus.mdu_op[3]) begin
                total++; bad++;
                $display("FAIL issue_while_busy actual=issue required=no_issue t=%0t", $time);
            end
            if (bus.busy) begin
                run++;
            end else if (busy_prev) begin
                if (abort) begin
                    abort = 1'b0;
                    if (sb.size() != 0) void'(sb.pop_front());
                end else if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_commit actual=commit required=none t=%0t", $time);
                end else begin
                    e = sb.pop_front();
                    chk("commit_hi", bus.hi, e.hi);
                    chk("commit_lo", bus.lo, e.lo);
                    chk("busy_len", 32'(run), 32'(e.n));
                end
                run = 0;
            end
            busy_prev = bus.busy;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic [3:0]  op;
        logic [31:0] ra, rb;
        int          r, guard;

        reset        = 1'b0;
        bus.issue    = 1'b0;
        bus.mdu_op   = 4'd15;
        bus.a        = 32'd0;
        bus.b        = 32'd0;
        bus.d_md_use = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        chk("rst_out", bus.mdu_out, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        do_op(4'd0, 32'hFFFF_FFFD, 32'd5, 1'b0);
        do_op(4'd4, 32'd0, 32'd0, 1'b0);
        do_op(4'd3, 32'd7, 32'd2, 1'b0);
        do_op(4'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        do_op(4'd6, 32'h0000_1234, 32'd0, 1'b0);
        do_op(4'd7, 32'h0000_5678, 32'd0, 1'b0);
        do_op(4'd2, 32'hDEAD_BEEF, 32'd0, 1'b0);
        do_op(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op(4'd5, 32'd0, 32'd0, 1'b0);

        // Stall window: issue cycle plus cycles 1..5, released in cycle 6.
        do_op(4'd0, 32'h0001_2345, 32'h0000_0678, 1'b1);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk); #1;
            chk("stall_busy", 32'(bus.stall_md), 32'd1);
        end
        @(negedge clk); #1;
        chk("stall_release", 32'(bus.stall_md), 32'd0);
        bus.issue  = 1'b1;
        bus.mdu_op = 4'd5;
        #1;
        chk("mflo_after_stall", bus.mdu_out, mdl_lo);
        @(posedge clk); #1;
        bus.issue    = 1'b0;
        bus.mdu_op   = 4'd15;
        bus.d_md_use = 1'b0;

        // Reset three cycles into a divide.
        do_op(4'd6, 32'hAAAA_5555, 32'd0, 1'b0);
        do_op(4'd3, 32'hFFFF_0000, 32'd3, 1'b0);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        reset = 1'b0;
        mdl_hi = 32'd0;
        mdl_lo = 32'd0;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_hi", bus.hi, 32'd0);
        chk("abort_lo", bus.lo, 32'd0);
        bus.d_md_use = 1'b1;
        #1;
        chk("abort_stall_idle", 32'(bus.stall_md), 32'd0);
        bus.issue  = 1'b1;
        bus.mdu_op = 4'd1;
        #1;
        chk("abort_stall_issue", 32'(bus.stall_md), 32'd1);
        bus.issue    = 1'b0;
        bus.mdu_op   = 4'd15;
        bus.d_md_use = 1'b0;
        @(posedge clk); #1;
        chk("abort_hold_hi", bus.hi, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        do_op(4'd0, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0);

        for (int i = 0; i < 40; i++) begin
            r  = int'($urandom_range(0, 9));
            op = (r < 8) ? 4'(r) : ((r == 8) ? 4'd15 : 4'd10);
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                3: rb = rb & 32'h0000_00FF;
                default: ;
            endcase
            do_op(op, ra, rb, 1'($urandom_range(0, 1)));
        end

        guard = 0;
        while ((sb.size() != 0 || bus.busy) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL drain actual=%0d required=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
